branch_ctrl: RTL

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl_if.sv | 36 +++
 rtl/branch_ctrl.sv | 91 +++++++++
 2 files changed

// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: ID-stage branch request, comparator and redirect signals of branch_ctrl
interface branch_ctrl_if;
    logic        i_br_valid;
    logic [2:0]  i_br_type;
    logic [31:0] i_rs_data;
    logic [31:0] i_rt_data;
    logic        i_rs_ready;
    logic        i_rt_ready;
    logic [31:0] i_target;
    logic        i_flush;
    logic        i_equal;
    logic        i_greater;
    logic        i_less;
    logic [31:0] o_cmp_a;
    logic [31:0] o_cmp_b;
    logic        o_stall;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic        o_busy;
    logic [15:0] o_br_cnt;
    logic [15:0] o_taken_cnt;

    modport master (
        output i_br_valid, i_br_type, i_rs_data, i_rt_data, i_rs_ready, i_rt_ready,
               i_target, i_flush, i_equal, i_greater, i_less,
        input  o_cmp_a, o_cmp_b, o_stall, o_redirect, o_redirect_pc, o_busy,
               o_br_cnt, o_taken_cnt
    );

    modport slave (
        input  i_br_valid, i_br_type, i_rs_data, i_rt_data, i_rs_ready, i_rt_ready,
               i_target, i_flush, i_equal, i_greater, i_less,
        output o_cmp_a, o_cmp_b, o_stall, o_redirect, o_redirect_pc, o_busy,
               o_br_cnt, o_taken_cnt
    );
endinterface

// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage conditional branch resolver with operand wait, shared comparator and counters
module branch_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    branch_ctrl_if.slave br
);
    typedef enum logic [1:0] {IDLE, WAIT, EVAL, DONE} state_t;

    state_t           r_state;
    logic [31:0]      r_op_a;
    logic [31:0]      r_op_b;
    logic [31:0]      r_target;
    logic [31:0]      r_redirect_pc;
    logic [2:0]       r_type;
    logic             r_redirect;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_taken_cnt;
    logic             w_two_op;
    logic             w_ready;
    logic             w_taken;

    // BEQ/BNE compare two registers; the other types compare rs against zero
    assign w_two_op = br.i_br_type[2:1] == 2'b00;
    assign w_ready  = br.i_rs_ready & (br.i_rt_ready | ~w_two_op);

    // Branch condition from the latched type and the shared comparator flags
    always_comb begin
        case (r_type)
            3'd0:    w_taken = br.i_equal;
            3'd1:    w_taken = ~br.i_equal;
            3'd2:    w_taken = br.i_greater;
            3'd3:    w_taken = ~br.i_greater;
            3'd4:    w_taken = br.i_less;
            3'd5:    w_taken = ~br.i_less;
            default: w_taken = 1'b0;
        endcase
    end

    // Control FSM with operand latch, registered redirect and saturating counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_target      <= '0;
            r_type        <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_br_cnt      <= '0;
            r_taken_cnt   <= '0;
        end else if (br.i_flush) begin
            r_state    <= IDLE;
            r_redirect <= 1'b0;
        end else begin
            case (r_state)
                IDLE, WAIT: begin
                    r_state <= !br.i_br_valid ? IDLE : w_ready ? EVAL : WAIT;
                    if (br.i_br_valid && w_ready) begin
                        r_op_a   <= br.i_rs_data;
                        r_op_b   <= w_two_op ? br.i_rt_data : 32'd0;
                        r_type   <= br.i_br_type;
                        r_target <= br.i_target;
                    end
                end
                EVAL: begin
                    r_state       <= DONE;
                    r_redirect    <= w_taken;
                    r_redirect_pc <= w_taken ? r_target : r_redirect_pc;
                    r_br_cnt      <= r_br_cnt + CNT_W'(~&r_br_cnt);
                    r_taken_cnt   <= r_taken_cnt + CNT_W'(w_taken & ~&r_taken_cnt);
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_redirect <= 1'b0;
                end
            endcase
        end
    end

    // Stall is gated by reset so a held br_valid cannot stall the pipe during reset
    assign br.o_stall       = rst_n & ((r_state == IDLE & br.i_br_valid) | r_state == WAIT | r_state == EVAL);
    assign br.o_busy        = r_state != IDLE;
    assign br.o_cmp_a       = r_op_a;
    assign br.o_cmp_b       = r_op_b;
    assign br.o_redirect    = r_redirect;
    assign br.o_redirect_pc = r_redirect_pc;
    assign br.o_br_cnt      = 16'(r_br_cnt);
    assign br.o_taken_cnt   = 16'(r_taken_cnt);
endmodule
